// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter fed by a small byte FIFO on a valid/ready write port
module uart_tx #(
    parameter int CLK_DIV    = 104,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [7:0]                    WR_DATA,
    input  logic                          WR_VALID,
    output logic                          WR_READY,
    output logic                          TX,
    output logic                          BUSY,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [1:0] IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3;
    localparam logic [15:0] LAST = 16'(CLK_DIV - 1);
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [1:0]    state;
    logic [15:0]   cnt;
    logic [2:0]    idx;
    logic [7:0]    shift;
    logic          push, pop, wrap, empty;
    assign empty    = FIFO_COUNT == '0;
    assign WR_READY = FIFO_COUNT != CW'(FIFO_DEPTH);
    assign BUSY     = state != IDLE || !empty;
    assign push     = WR_VALID && WR_READY;
    assign wrap     = cnt == LAST;
    // The end of a stop bit reloads directly, so back-to-back frames have no idle gap
    assign pop      = !empty && (state == IDLE || (state == STOP && wrap));
    always_ff @(posedge CLK) begin
        if (push) mem[wptr] <= WR_DATA;
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            wptr       <= '0;
            rptr       <= '0;
            FIFO_COUNT <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop) rptr <= rptr + AW'(1);
            FIFO_COUNT <= FIFO_COUNT + CW'(push) - CW'(pop);
        end
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shift <= '0;
            TX    <= 1'b1;
        end else begin
            cnt <= (state == IDLE || wrap) ? '0 : cnt + 16'd1;
            if (pop) begin
                shift <= mem[rptr];
                state <= START;
                TX    <= 1'b0;
            end else if (state != IDLE && wrap) begin
                if (state == START) begin
                    state <= DATA;
                    idx   <= '0;
                    TX    <= shift[0];
                end else if (state == DATA) begin
                    shift <= shift >> 1;
                    idx   <= idx + 3'd1;
                    state <= idx == 3'd7 ? STOP : DATA;
                    TX    <= idx == 3'd7 ? 1'b1 : shift[1];
                end else begin
                    state <= IDLE;
                    TX    <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: random and directed traffic checked cycle by cycle against a frame-schedule model
module tb_uart_tx;
    localparam int D = 4;
    localparam int N = 4;
    localparam int FL = 10 * D;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] wr_data = '0;
    logic       wr_valid = 1'b0;
    logic       wr_ready, tx, busy;
    logic [2:0] fifo_count;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_end = 0;
    int last_start = 0;
    typedef struct {
        int         start;
        logic [7:0] data;
    } frame_t;
    frame_t fq[$];

    uart_tx #(.CLK_DIV(D), .FIFO_DEPTH(N)) dut (
        .CLK(clk), .RST(rst), .WR_DATA(wr_data), .WR_VALID(wr_valid),
        .WR_READY(wr_ready), .TX(tx), .BUSY(busy), .FIFO_COUNT(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // Bytes accepted but whose frame has not started yet are the ones still in the FIFO
    function automatic int qcount(input int e);
        int n = 0;
        foreach (fq[i]) if (fq[i].start > e) n++;
        return n;
    endfunction

    function automatic logic exp_tx(input int e);
        int b;
        foreach (fq[i]) begin
            if (fq[i].start <= e && e < fq[i].start + FL) begin
                b = (e - fq[i].start) / D;
                if (b == 0) return 1'b0;
                if (b == 9) return 1'b1;
                return fq[i].data[b-1];
            end
        end
        return 1'b1;
    endfunction

    function automatic logic exp_busy(input int e);
        foreach (fq[i]) if (fq[i].start + FL > e) return 1'b1;
        return 1'b0;
    endfunction

    task automatic step(input logic r, input logic v, input logic [7:0] d, output logic acc);
        logic rdy;
        @(negedge clk);
        rst = r;
        wr_valid = v;
        wr_data = d;
        rdy = qcount(cyc) < N;
        @(posedge clk);
        cyc++;
        acc = !r && v && rdy;
        if (r) begin
            fq.delete();
            last_end = 0;
        end else if (acc) begin
            last_start = (cyc + 1 > last_end) ? cyc + 1 : last_end;
            last_end = last_start + FL;
            fq.push_back('{last_start, d});
        end
        #1;
        chk("tx", tx, exp_tx(cyc));
        chk("ready", wr_ready, qcount(cyc) < N);
        chk("busy", busy, exp_busy(cyc));
        chk("count", fifo_count, qcount(cyc));
        while (fq.size() > 0 && fq[0].start + FL <= cyc) void'(fq.pop_front());
    endtask

    task automatic drain();
        logic a;
        for (int k = 0; k < 600 && exp_busy(cyc); k++) step(1'b0, 1'b0, 8'h00, a);
        step(1'b0, 1'b0, 8'h00, a);
    endtask

    initial begin
        logic a;
        int i, s, tries;
        step(1'b1, 1'b0, 8'h00, a);
        step(1'b1, 1'b0, 8'h00, a);
        for (int k = 0; k < 50; k++) step(1'b0, 1'b0, 8'h00, a);
        step(1'b0, 1'b1, 8'hA5, a);
        chk("accept_a5", a, 1);
        drain();
        i = 0;
        tries = 0;
        while (i < 6 && tries < 400) begin
            step(1'b0, 1'b1, 8'(i + 1), a);
            if (a) i++;
            tries++;
        end
        chk("fill_done", i, 6);
        drain();
        step(1'b0, 1'b1, 8'h0E, a);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 8'(8'h10 + k), a);
        for (int k = 0; k < 30 && qcount(cyc) >= N; k++) step(1'b0, 1'b1, 8'hFF, a);
        drain();
        i = 0;
        tries = 0;
        while (i < 20 && tries < 2000) begin
            step(1'b0, 1'($urandom_range(0, 1)), 8'(i), a);
            if (a) i++;
            tries++;
        end
        chk("wrap_done", i, 20);
        drain();
        step(1'b0, 1'b1, 8'h5A, a);
        s = last_start;
        step(1'b0, 1'b1, 8'h11, a);
        step(1'b0, 1'b1, 8'h22, a);
        while (cyc < s + 17) step(1'b0, 1'b0, 8'h00, a);
        step(1'b1, 1'b0, 8'h00, a);
        for (int k = 0; k < 100; k++) step(1'b0, 1'b0, 8'h00, a);
        for (int k = 0; k < 600; k++)
            step(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 2) != 0), 8'($urandom), a);
        drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
